single_mips_fetch_unit: RTL and testbench
=========================================

# single_mips_fetch_unit

Instruction-fetch stage for the single-cycle MIPS core.
- Owns the program counter and fetches one instruction at a time from a variable-latency instruction memory using a request/acknowledge handshake.
- Presents the instruction to the main decoder (OP_CODE = INSTR[31:26]) for exactly one execute cycle.
- Resolves the next PC from the decoder's BRANCH/JUMP outputs and the ALU zero flag.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- CLK  in  1  core clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- IMEM_REQ  out  1  fetch request to instruction memory
- IMEM_ADDR  out  32  fetch address; equals PC
- IMEM_ACK  in  1  instruction memory data valid; honoured only while IMEM_REQ=1
- IMEM_RDATA  in  32  instruction word, valid when IMEM_ACK=1
- INSTR  out  32  captured instruction; drives decoder, register file, sign-extend
- INSTR_VALID  out  1  high for exactly one cycle per instruction (the execute cycle)
- PC  out  32  address of INSTR
- PC_PLUS4  out  32  PC + 4
- BRANCH  in  1  from main decoder; ignored when JUMP=1 (decoder may drive X)
- ZERO  in  1  ALU zero flag
- JUMP  in  1  from main decoder
- RETIRED_CNT  out  32  count of completed execute cycles

## Operation
- FSM states:
  - IDLE: entered on reset; exactly one cycle, then go to REQ.
  - REQ: IMEM_REQ=1. On a cycle with IMEM_ACK=1, capture IMEM_RDATA into INSTR and go to EXEC. Otherwise stay in REQ.
  - EXEC: INSTR_VALID=1. Load the next PC into PC, increment RETIRED_CNT, go to REQ.
- Next-PC selection in EXEC, highest priority first:
  - JUMP=1: {PC_PLUS4[31:28], INSTR[25:0], 2'b00}. BRANCH and ZERO are don't-care and must not propagate X into PC.
  - BRANCH=1 and ZERO=1: PC_PLUS4 + (sign-extended INSTR[15:0] << 2), modulo 2^32.
  - Otherwise: PC_PLUS4.
- PC_PLUS4 is combinational from PC; wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- BRANCH, ZERO and JUMP are sampled only in EXEC; their values in any other state have no effect.
- INSTR holds its value from capture through the end of EXEC and until the next capture.
- IMEM_ACK outside REQ is ignored; it includes a stale ACK arriving after reset.
- RETIRED_CNT wraps modulo 2^32.

## Timing
- Reset values (applied asynchronously):
  - State IDLE
  - PC = RESET_PC, PC_PLUS4 = RESET_PC + 4
  - IMEM_REQ = 0, IMEM_ADDR = RESET_PC
  - INSTR = 0, INSTR_VALID = 0
  - RETIRED_CNT = 0
- Reset released at edge N: IMEM_REQ rises after edge N+1.
- Zero-wait memory (ACK in the first REQ cycle): 2 cycles per instruction, REQ then EXEC. Each memory wait cycle adds one cycle.
- IMEM_ADDR and IMEM_REQ stay stable while waiting for ACK; the address never changes mid-request.
- The new PC is visible on IMEM_ADDR in the cycle after EXEC, with IMEM_REQ=1.
- Reset mid-request or mid-EXEC: IMEM_REQ drops immediately, with no retirement and no PC update. The outstanding request is abandoned.
- INSTR_VALID is never high on two consecutive cycles.

## Structure
- Shared package single_mips_pkg holds:
  - fetch state enum (IDLE, REQ, EXEC)
  - instruction field position constants: opcode [31:26], jump index [25:0], immediate [15:0]
  - instruction width constant (32)
- Sub-module single_mips_next_pc is purely combinational. It takes PC_PLUS4, INSTR, BRANCH, ZERO and JUMP and produces the next PC.
- The FSM, PC register, instruction register and counter live in the top module.

## Test plan
- Reset with RESET_PC=32'h0000_0040 and ACK tied high:
  - IMEM_ADDR sequence is 0x40, 0x44, 0x48.
  - INSTR_VALID pulses every 2nd cycle; RETIRED_CNT=3 after the third EXEC.
- ACK delayed 3 cycles:
  - IMEM_REQ stays high and IMEM_ADDR stays stable for 3 cycles.
  - ACK arriving outside REQ produces no capture.
- beq taken at PC=0x100, INSTR[15:0]=16'hFFFE, BRANCH=1, ZERO=1: next IMEM_ADDR=0x0FC. With ZERO=0: next IMEM_ADDR=0x104.
- j at PC=0x1000_0000, INSTR[25:0]=26'h000_0010, JUMP=1, BRANCH=X: next IMEM_ADDR=0x1000_0040, with no X on PC.
- Wrap-around: PC=0xFFFF_FFFC, sequential instruction -> next IMEM_ADDR=0x0000_0000.
- RST asserted mid-wait at PC=0x200:
  - IMEM_REQ=0 immediately; PC=RESET_PC; RETIRED_CNT=0.
  - Late ACK while in IDLE is ignored; refetch starts at RESET_PC.

Source files
------------

// File: rtl/single_mips_pkg.sv
// Shared definitions for the single-cycle MIPS fetch path: fetch FSM states,
// instruction field positions and a sign-extension helper.
package single_mips_pkg;

  localparam int INSTR_W = 32;

  // Instruction field positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int JIDX_MSB   = 25;
  localparam int JIDX_LSB   = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam int JIDX_W = JIDX_MSB - JIDX_LSB + 1;
  localparam int IMM_W  = IMM_MSB - IMM_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2
  } fetch_state_t;

  // Sign-extend the 16-bit immediate to a full word
  function automatic logic [31:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
    return {{(32 - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/single_mips_next_pc.sv
// Combinational next-PC selection: jump beats taken branch beats PC+4.
// Only the low 26 instruction bits (jump index, which contains the
// immediate) influence the target, so only those are brought in.
module single_mips_next_pc
  import single_mips_pkg::*;
(
  input  logic [31:0]       pc_plus4,
  input  logic [JIDX_W-1:0] instr_field,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  output logic [31:0]       next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;

  assign jump_target   = {pc_plus4[31:28], instr_field, 2'b00};
  assign branch_target = pc_plus4 + (sign_ext_imm(instr_field[IMM_MSB:IMM_LSB]) << 2);

  // Jump is tested first so a don't-care branch/zero can never leak into the PC
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/single_mips_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// presents each instruction for one execute cycle and retires it.
module single_mips_fetch_unit
  import single_mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               IMEM_REQ,
  output logic [31:0]        IMEM_ADDR,
  input  logic               IMEM_ACK,
  input  logic [31:0]        IMEM_RDATA,
  output logic [INSTR_W-1:0] INSTR,
  output logic               INSTR_VALID,
  output logic [31:0]        PC,
  output logic [31:0]        PC_PLUS4,
  input  logic               BRANCH,
  input  logic               ZERO,
  input  logic               JUMP,
  output logic [31:0]        RETIRED_CNT
);

  fetch_state_t       state_reg;
  logic [31:0]        pc_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic               imem_req_reg;
  logic               instr_valid_reg;
  logic [31:0]        retired_cnt_reg;
  logic [31:0]        pc_plus4;
  logic [31:0]        next_pc;

  assign pc_plus4 = pc_reg + 32'd4;

  single_mips_next_pc u_next_pc (
    .pc_plus4    (pc_plus4),
    .instr_field (instr_reg[JIDX_MSB:JIDX_LSB]),
    .branch      (BRANCH),
    .zero        (ZERO),
    .jump        (JUMP),
    .next_pc     (next_pc)
  );

  // Fetch FSM with registered request/valid outputs; the PC only moves at the
  // end of EXEC, so the address is stable for the whole request
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= RESET_PC;
      instr_reg       <= '0;
      imem_req_reg    <= 1'b0;
      instr_valid_reg <= 1'b0;
      retired_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg    <= ST_REQ;
          imem_req_reg <= 1'b1;
        end
        ST_REQ: begin
          if (IMEM_ACK) begin
            instr_reg       <= IMEM_RDATA;
            state_reg       <= ST_EXEC;
            imem_req_reg    <= 1'b0;
            instr_valid_reg <= 1'b1;
          end
        end
        ST_EXEC: begin
          pc_reg          <= next_pc;
          retired_cnt_reg <= retired_cnt_reg + 32'd1;
          state_reg       <= ST_REQ;
          imem_req_reg    <= 1'b1;
          instr_valid_reg <= 1'b0;
        end
        default: begin
          state_reg       <= ST_IDLE;
          imem_req_reg    <= 1'b0;
          instr_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign IMEM_REQ    = imem_req_reg;
  assign IMEM_ADDR   = pc_reg;
  assign INSTR       = instr_reg;
  assign INSTR_VALID = instr_valid_reg;
  assign PC          = pc_reg;
  assign PC_PLUS4    = pc_plus4;
  assign RETIRED_CNT = retired_cnt_reg;

endmodule

// File: tb/tb_single_mips_fetch_unit.sv
// Scoreboard bench for the fetch unit: a memory-responder process issues
// instructions and pushes expected retirements; a monitor pops and compares.
module tb_single_mips_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] retired_cnt;

  always #5 clk = ~clk;

  single_mips_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .CLK         (clk),
    .RST         (rst),
    .IMEM_REQ    (imem_req),
    .IMEM_ADDR   (imem_addr),
    .IMEM_ACK    (imem_ack),
    .IMEM_RDATA  (imem_rdata),
    .INSTR       (instr),
    .INSTR_VALID (instr_valid),
    .PC          (pc),
    .PC_PLUS4    (pc_plus4),
    .BRANCH      (branch),
    .ZERO        (zero),
    .JUMP        (jump),
    .RETIRED_CNT (retired_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic        b;
    logic        z;
    logic        j;
    int          delay;
    logic [31:0] exp_next;
    bit          has_exp;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] next_pc;
    logic [31:0] cnt;
    int          delay;
  } txn_t;

  stim_t dir_q[$];
  txn_t  sb_q[$];
  int    rand_left = 0;
  int    checks = 0;
  int    failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference next-PC from the architectural rules
  function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                           input logic b, input logic z, input logic j);
    logic [31:0] p4;
    p4 = cur_pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ({6'b0, ins[25:0]} * 32'd4);
    if (b && z) return p4 + 32'(int'($signed(ins[15:0])) * 4);
    return p4;
  endfunction

  function automatic stim_t mk(input logic [31:0] ins, input logic b, input logic z,
                               input logic j, input int d, input logic [31:0] nxt);
    stim_t s;
    s.instr = ins; s.b = b; s.z = z; s.j = j; s.delay = d;
    s.exp_next = nxt; s.has_exp = 1'b1;
    return s;
  endfunction

  function automatic stim_t mk_seq(input int d, input logic [31:0] nxt);
    return mk($urandom, 1'($urandom_range(1)), 1'b0, 1'b0, d, nxt);
  endfunction

  function automatic stim_t mk_j(input logic [25:0] idx, input logic [31:0] nxt);
    return mk({6'h02, idx}, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 0, nxt);
  endfunction

  function automatic stim_t mk_beq(input logic [15:0] imm, input logic z, input logic [31:0] nxt);
    return mk({6'h04, 5'd1, 5'd2, imm}, 1'b1, z, 1'b0, 0, nxt);
  endfunction

  // ---------------- memory responder / stimulus driver ----------------
  bit          drv_active = 0;
  bit          drv_just_acked = 0;
  int          drv_wait = 0;
  stim_t       drv_cur;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] model_cnt = '0;

  always @(negedge clk) begin
    txn_t t;
    if (rst) begin
      drv_active = 0;
      drv_just_acked = 0;
      model_pc = RESET_PC;
      model_cnt = '0;
      sb_q.delete();
      imem_ack = 1'b1;            // stale ACK during reset and the idle cycle
      imem_rdata = $urandom;
      branch = 1'($urandom_range(1));
      zero = 1'($urandom_range(1));
      jump = 1'($urandom_range(1));
    end else if (imem_req) begin
      if (!drv_active && (dir_q.size() > 0 || rand_left > 0)) begin
        if (dir_q.size() > 0) begin
          drv_cur = dir_q.pop_front();
        end else begin
          drv_cur.instr = $urandom;
          drv_cur.j = ($urandom_range(3) == 0);
          drv_cur.b = 1'($urandom_range(1));
          drv_cur.z = 1'($urandom_range(1));
          drv_cur.delay = $urandom_range(3);
          drv_cur.has_exp = 1'b0;
          drv_cur.exp_next = '0;
          rand_left--;
        end
        drv_active = 1;
        drv_wait = drv_cur.delay;
      end
      if (drv_active && drv_wait == 0) begin
        imem_ack = 1'b1;
        imem_rdata = drv_cur.instr;
        branch = drv_cur.b;
        zero = drv_cur.z;
        jump = drv_cur.j;
        t.pc = model_pc;
        t.instr = drv_cur.instr;
        t.cnt = model_cnt;
        t.delay = drv_cur.delay;
        t.next_pc = drv_cur.has_exp ? drv_cur.exp_next
                  : ref_next(model_pc, drv_cur.instr, drv_cur.b, drv_cur.z, drv_cur.j);
        sb_q.push_back(t);
        model_pc = t.next_pc;
        model_cnt = model_cnt + 32'd1;
        drv_active = 0;
        drv_just_acked = 1;
      end else begin
        if (drv_active) drv_wait--;
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        branch = 1'($urandom_range(1));
        zero = 1'($urandom_range(1));
        jump = 1'($urandom_range(1));
      end
    end else begin
      // Execute cycle keeps the decoder outputs; elsewhere they are noise
      if (!drv_just_acked) begin
        branch = 1'($urandom_range(1));
        zero = 1'($urandom_range(1));
        jump = 1'($urandom_range(1));
      end
      drv_just_acked = 0;
      imem_ack = 1'($urandom_range(1));   // stray ACK outside a request
      imem_rdata = $urandom;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          cyc = 0;
  int          ref_cyc = 0;
  bit          prev_rst = 1;
  bit          prev_valid = 0;
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] last_instr = '0;
  int          retired_seen = 0;
  bit          saw_200 = 0;

  always @(posedge clk) begin
    txn_t t;
    #1;
    cyc++;
    if (rst) begin
      check32("rst_req", 32'(imem_req), 32'd0);
      check32("rst_valid", 32'(instr_valid), 32'd0);
      check32("rst_pc", pc, RESET_PC);
      check32("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
      check32("rst_addr", imem_addr, RESET_PC);
      check32("rst_instr", instr, 32'd0);
      check32("rst_retired", retired_cnt, 32'd0);
      exp_addr = RESET_PC;
      last_instr = '0;
      ref_cyc = cyc;
      prev_valid = 0;
      retired_seen = 0;
      prev_rst = 1;
    end else begin
      if (prev_rst) check32("idle_one_cycle_req", 32'(imem_req), 32'd1);
      if (prev_valid) begin
        check32("req_after_exec", 32'(imem_req), 32'd1);
        check32("valid_not_consecutive", 32'(instr_valid), 32'd0);
      end
      if (imem_req) begin
        check32("imem_addr", imem_addr, exp_addr);
        if (imem_addr == 32'h0000_0200) saw_200 = 1;
      end
      if (instr_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got valid at pc %h expected no instruction", pc);
        end else begin
          t = sb_q.pop_front();
          check32("exec_pc", pc, t.pc);
          check32("exec_pc_plus4", pc_plus4, t.pc + 32'd4);
          check32("exec_instr", instr, t.instr);
          check32("exec_retired", retired_cnt, t.cnt);
          check32("exec_gap", 32'(cyc - ref_cyc), 32'(t.delay + 2));
          check32("exec_req_low", 32'(imem_req), 32'd0);
          $display("txn pc=%h instr=%h next=%h cnt=%0d delay=%0d",
                   t.pc, t.instr, t.next_pc, t.cnt, t.delay);
          exp_addr = t.next_pc;
          last_instr = t.instr;
          retired_seen++;
        end
        ref_cyc = cyc;
      end else begin
        check32("instr_hold", instr, last_instr);
      end
      prev_valid = instr_valid;
      prev_rst = 0;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    bit done;
    // From reset at 0x40: sequential, delayed ACK, jump, branches, wrap, then to 0x200
    dir_q.push_back(mk_seq(0, 32'h0000_0044));
    dir_q.push_back(mk_seq(0, 32'h0000_0048));
    dir_q.push_back(mk_seq(0, 32'h0000_004C));
    dir_q.push_back(mk_seq(3, 32'h0000_0050));
    dir_q.push_back(mk_j(26'h000_0040, 32'h0000_0100));
    dir_q.push_back(mk_beq(16'hFFFE, 1'b1, 32'h0000_00FC));
    dir_q.push_back(mk_j(26'h000_0040, 32'h0000_0100));
    dir_q.push_back(mk_beq(16'hFFFE, 1'b0, 32'h0000_0104));
    dir_q.push_back(mk_beq(16'hFFBD, 1'b1, 32'hFFFF_FFFC));
    dir_q.push_back(mk_seq(0, 32'h0000_0000));
    dir_q.push_back(mk_j(26'h000_0080, 32'h0000_0200));
    dir_q.push_back(mk_seq(10, 32'h0000_0204));   // abandoned by reset

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(posedge clk);
      done = saw_200;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_pc_200: got no request at 00000200 expected one within 600 cycles");
    end

    repeat (3) @(negedge clk);
    check32("phase1_retired", 32'(retired_seen), 32'd11);
    #2 rst = 1'b1;
    #1;
    check32("midreq_rst_req", 32'(imem_req), 32'd0);
    check32("midreq_rst_pc", pc, RESET_PC);
    check32("midreq_rst_retired", retired_cnt, 32'd0);
    check32("midreq_rst_addr", imem_addr, RESET_PC);

    repeat (2) @(negedge clk);
    dir_q.delete();
    dir_q.push_back(mk_seq(0, 32'h0000_0044));
    dir_q.push_back(mk_j(26'h3FF_FFFF, 32'h0FFF_FFFC));
    dir_q.push_back(mk_seq(1, 32'h1000_0000));
    dir_q.push_back(mk_j(26'h000_0010, 32'h1000_0040));
    rand_left = 40;
    #2 rst = 1'b0;

    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      done = (retired_seen >= 44);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_phase2: got %0d retirements expected 44 within 3000 cycles", retired_seen);
    end
    repeat (2) @(posedge clk);
    #2;
    check32("phase2_retired", 32'(retired_seen), 32'd44);
    check32("final_retired_cnt", retired_cnt, 32'd44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
